rom_image_streamer: RTL and testbench

//  Streams a ROM image of WORD_COUNT words into the hack_soc ROM loader port (load/sck/data/ack) at boot.

---
 rtl/rom_streamer_pkg.sv | 26 ++
 rtl/rom_image_mem.sv | 33 +++
 rtl/rom_image_streamer.sv | 172 +++++++++++++++++
 tb/tb_rom_image_streamer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_streamer_pkg.sv
// Shared definitions for the ROM image streamer: FSM state encoding and
// the CRC-16/CCITT constants plus a single-bit CRC step helper.
package rom_streamer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LATCH,
      SETUP,
      SCK_HI,
      WAIT_ACK,
      DONE,
      ERROR
   } state_t;

   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

   // One MSB-first CRC-16/CCITT shift step for a single data bit
   function automatic logic [15:0] crc16_bit(input logic [15:0] crc, input logic din);
      logic fb;
      fb = crc[15] ^ din;
      return fb ? ((crc << 1) ^ CRC_POLY) : (crc << 1);
   endfunction

endpackage

// File: rtl/rom_image_mem.sv
// Image source for the streamer: a word-wide memory with a synchronous read
// port (data valid one cycle after rd_en) and a write port used to fill it.
// Addresses at or beyond DEPTH are ignored on write.
module rom_image_mem #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16,
   parameter int DEPTH      = 1000
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Write the image and return the addressed word one cycle after a read strobe
   always_ff @(posedge clk) begin
      if (wr_en && ({1'b0, wr_addr} < LIMIT)) begin
         mem[wr_addr[IW-1:0]] <= wr_data;
      end
      if (rd_en && ({1'b0, rd_addr} < LIMIT)) begin
         rd_data <= mem[rd_addr[IW-1:0]];
      end
   end

endmodule

// File: rtl/rom_image_streamer.sv
// Streams WORD_COUNT words from a synchronous-read image source into the
// SoC ROM loader port (load/sck/data/ack) and holds the CPU in reset until
// the whole image has been acknowledged. Supports abort (run low) and re-run.
// Optional feature: define ROM_STREAMER_CRC_EN to add a CRC-16/CCITT output
// computed over every latched word.
module rom_image_streamer
   import rom_streamer_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int WORD_COUNT  = 1000,
   parameter int ADDR_WIDTH  = 16,
   parameter int SCK_HALF    = 2,
   parameter int ACK_TIMEOUT = 4096
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  run,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH-1:0] word_index,
   output logic                  cpu_hold_reset,
   output logic                  src_en,
   output logic [ADDR_WIDTH-1:0] src_addr,
   input  logic [DATA_WIDTH-1:0] src_data,
   output logic                  rom_loader_load,
   output logic                  rom_loader_sck,
   output logic [DATA_WIDTH-1:0] rom_loader_data,
`ifdef ROM_STREAMER_CRC_EN
   output logic [15:0]           crc,
`endif
   input  logic                  rom_loader_ack
);

   localparam int PW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
   localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [PW-1:0] PHASE_LAST = PW'(SCK_HALF - 1);
   localparam logic [TW-1:0] TIME_LAST  = TW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
   localparam logic [ADDR_WIDTH-1:0] WORD_LAST = ADDR_WIDTH'(WORD_COUNT - 1);

   state_t state, next_state;

   logic          run_q;
   logic          ack_s1, ack_s2;
   logic          ack_taken;
   logic [PW-1:0] phase_cnt;
   logic [TW-1:0] time_cnt;
   logic          run_rise;
   logic          in_busy;
   logic          timeout_hit;
   logic          starting;

   assign run_rise    = run & ~run_q;
   assign in_busy     = (state == FETCH) || (state == LATCH) || (state == SETUP) ||
                        (state == SCK_HI) || (state == WAIT_ACK);
   assign timeout_hit = (ACK_TIMEOUT != 0) && (time_cnt == TIME_LAST);
   assign starting    = ((state == IDLE) || (state == DONE) || (state == ERROR)) &&
                        (next_state == FETCH);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; ack is accepted once, then the line must drop before the next fetch
   always_comb begin
      next_state = state;
      case (state)
         IDLE, DONE, ERROR: if (run_rise) next_state = FETCH;
         FETCH:             next_state = LATCH;
         LATCH:             next_state = SETUP;
         SETUP:             if (phase_cnt == PHASE_LAST) next_state = SCK_HI;
         SCK_HI:            if (phase_cnt == PHASE_LAST) next_state = WAIT_ACK;
         WAIT_ACK: begin
            if (!ack_taken && ack_s2) begin
               if (word_index == WORD_LAST) next_state = DONE;
            end else if (ack_taken && !ack_s2) begin
               next_state = FETCH;
            end else if (!ack_taken && timeout_hit) begin
               next_state = ERROR;
            end
         end
         default:           next_state = IDLE;
      endcase
      if (in_busy && !run) next_state = IDLE;
   end

   // Moore outputs decoded from the current state
   always_comb begin
      busy            = in_busy;
      rom_loader_load = in_busy;
      rom_loader_sck  = (state == SCK_HI);
      done            = (state == DONE);
      error           = (state == ERROR);
      cpu_hold_reset  = (state != DONE);
      src_en          = (state == FETCH);
      src_addr        = word_index;
   end

   // Datapath: run edge detect, ack synchronizer, phase/timeout counters, word index and data latch
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         run_q           <= 1'b0;
         ack_s1          <= 1'b0;
         ack_s2          <= 1'b0;
         ack_taken       <= 1'b0;
         phase_cnt       <= '0;
         time_cnt        <= '0;
         word_index      <= '0;
         rom_loader_data <= '0;
      end else begin
         run_q  <= run;
         ack_s1 <= rom_loader_ack;
         ack_s2 <= ack_s1;

         if (state != next_state) begin
            phase_cnt <= '0;
         end else if ((state == SETUP) || (state == SCK_HI)) begin
            phase_cnt <= phase_cnt + PW'(1);
         end

         if ((state != WAIT_ACK) && (next_state == WAIT_ACK)) begin
            time_cnt <= '0;
         end else if ((state == WAIT_ACK) && !ack_taken) begin
            time_cnt <= time_cnt + TW'(1);
         end

         if (next_state != WAIT_ACK) begin
            ack_taken <= 1'b0;
         end else if ((state == WAIT_ACK) && !ack_taken && ack_s2) begin
            ack_taken <= 1'b1;
         end

         if (starting) begin
            word_index <= '0;
         end else if ((state == WAIT_ACK) && (next_state == FETCH)) begin
            word_index <= word_index + ADDR_WIDTH'(1);
         end

         if (state == LATCH) begin
            rom_loader_data <= src_data;
         end
      end
   end

`ifdef ROM_STREAMER_CRC_EN
   function automatic logic [15:0] crc_word(input logic [15:0] c, input logic [DATA_WIDTH-1:0] w);
      logic [15:0] r;
      r = c;
      for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
         r = crc16_bit(r, w[i]);
      end
      return r;
   endfunction

   // Running CRC over each word as it is latched, restarted on every new load
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         crc <= CRC_INIT;
      end else if (starting) begin
         crc <= CRC_INIT;
      end else if (state == LATCH) begin
         crc <= crc_word(crc, src_data);
      end
   end
`endif

endmodule

// File: tb/tb_rom_image_streamer.sv
// Self-checking bench for rom_image_streamer with a 4-word image, SCK_HALF=1
// and ACK_TIMEOUT=16. An ack responder plays the SoC side; a scoreboard checks
// word order and port relationships every cycle; directed tests cover normal
// load, abort/re-run, ack timeout, async reset and a stuck ack line.
// Honours ROM_STREAMER_CRC_EN when defined.
module tb_rom_image_streamer;

   localparam int DW = 16;
   localparam int WC = 4;
   localparam int AW = 16;
   localparam int SH = 1;
   localparam int AT = 16;

   logic          clk;
   logic          reset;
   logic          run;
   logic          busy, done, error;
   logic [AW-1:0] word_index;
   logic          cpu_hold_reset;
   logic          src_en;
   logic [AW-1:0] src_addr;
   logic [DW-1:0] src_data;
   logic          load, sck;
   logic [DW-1:0] data;
   logic          ack;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
`ifdef ROM_STREAMER_CRC_EN
   logic [15:0]   crc;
`endif

   int checks = 0;
   int errors = 0;
   int ack_mode = 0;
   int ack_count = 0;
   int start_seq = 0;
   int sck_rises = 0;
   logic [DW-1:0] img [WC];

   rom_image_streamer #(
      .DATA_WIDTH(DW), .WORD_COUNT(WC), .ADDR_WIDTH(AW), .SCK_HALF(SH), .ACK_TIMEOUT(AT)
   ) dut (
      .clk(clk), .reset(reset), .run(run), .busy(busy), .done(done), .error(error),
      .word_index(word_index), .cpu_hold_reset(cpu_hold_reset), .src_en(src_en),
      .src_addr(src_addr), .src_data(src_data), .rom_loader_load(load),
      .rom_loader_sck(sck), .rom_loader_data(data),
`ifdef ROM_STREAMER_CRC_EN
      .crc(crc),
`endif
      .rom_loader_ack(ack)
   );

   rom_image_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(WC)) image (
      .clk(clk), .wr_en(mem_we), .wr_addr(mem_addr), .wr_data(mem_data),
      .rd_en(src_en), .rd_addr(src_addr), .rd_data(src_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic r, input int mode);
      @(negedge clk);
      if (r && !run) start_seq++;
      run = r;
      ack_mode = mode;
   endtask

   // cond: 0 done, 1 error, 2 sck high, 3 sck low, 4 ack_count >= target
   task automatic waitFor(input string name, input int cond, input int target, input int budget);
      int n;
      bit hit;
      n = 0;
      hit = 1'b0;
      while (n < budget && !hit) begin
         @(negedge clk);
         n++;
         case (cond)
            0:       hit = done;
            1:       hit = error;
            2:       hit = sck;
            3:       hit = !sck;
            default: hit = (ack_count >= target);
         endcase
      end
      checkOutput(name, {31'd0, hit}, 32'd1);
   endtask

`ifdef ROM_STREAMER_CRC_EN
   function automatic logic [15:0] ref_crc();
      logic [15:0] c;
      logic top;
      c = 16'hFFFF;
      for (int w = 0; w < WC; w++) begin
         for (int b = DW - 1; b >= 0; b--) begin
            top = c[15] ^ img[w][b];
            c = {c[14:0], 1'b0};
            if (top) c = c ^ 16'h1021;
         end
      end
      return c;
   endfunction
`endif

   // SoC side: ack rises 3 cycles after each sck rise and stays high 2 cycles
   initial begin
      int ack_cnt;
      int ack_high;
      logic sck_prev;
      ack_cnt = 0;
      ack_high = 0;
      sck_prev = 1'b0;
      ack = 1'b0;
      forever begin
         @(negedge clk);
         if (ack_mode == 1) begin
            ack_cnt = 0;
            ack_high = 0;
            ack = 1'b0;
         end else if (ack_mode == 2) begin
            ack_cnt = 0;
            ack_high = 0;
            ack = 1'b1;
         end else begin
            if (sck && !sck_prev) begin
               ack_cnt = 3;
            end else if (ack_cnt > 0) begin
               ack_cnt--;
               if (ack_cnt == 0) begin
                  ack_high = 2;
                  ack_count++;
               end
            end else if (ack_high > 0) begin
               ack_high--;
            end
            ack = (ack_high > 0);
         end
         sck_prev = sck;
      end
   end

   // Scoreboard: words must leave in image order, one per sck pulse, and port relations must hold
   initial begin
      int model_idx;
      int seen_seq;
      logic sck_prev;
      logic done_prev;
      model_idx = 0;
      seen_seq = 0;
      sck_prev = 1'b0;
      done_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (start_seq != seen_seq) begin
            seen_seq = start_seq;
            model_idx = 0;
         end
         if (reset === 1'b0) begin
            checkOutput("hold_vs_done", {31'd0, cpu_hold_reset}, {31'd0, !done});
            checkOutput("busy_vs_load", {31'd0, busy}, {31'd0, load});
            if (sck && !sck_prev) begin
               sck_rises++;
               checkOutput("sck_word_index", 32'(word_index), 32'(model_idx));
               checkOutput("sck_load", {31'd0, load}, 32'd1);
               if (model_idx < WC) begin
                  checkOutput("sck_data", 32'(data), 32'(img[model_idx]));
               end else begin
                  checkOutput("extra_word", 32'(model_idx), 32'(WC - 1));
               end
               model_idx++;
            end
            if (src_en) checkOutput("src_addr", 32'(src_addr), 32'(model_idx));
            if (done && !done_prev) begin
               checkOutput("words_at_done", 32'(model_idx), 32'(WC));
`ifdef ROM_STREAMER_CRC_EN
               checkOutput("crc_at_done", 32'(crc), 32'(ref_crc()));
`endif
            end
         end
         sck_prev = sck;
         done_prev = done;
      end
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: got timeout want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence
   initial begin
      int snap;
      int cnt;
      reset = 1'b1;
      run = 1'b0;
      mem_we = 1'b0;
      mem_addr = '0;
      mem_data = '0;
      img = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};

      repeat (2) @(negedge clk);
      #1;
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_done", {31'd0, done}, 32'd0);
      checkOutput("rst_error", {31'd0, error}, 32'd0);
      checkOutput("rst_load", {31'd0, load}, 32'd0);
      checkOutput("rst_sck", {31'd0, sck}, 32'd0);
      checkOutput("rst_data", 32'(data), 32'd0);
      checkOutput("rst_index", 32'(word_index), 32'd0);
      checkOutput("rst_src_en", {31'd0, src_en}, 32'd0);
      checkOutput("rst_hold", {31'd0, cpu_hold_reset}, 32'd1);

      for (int i = 0; i < WC; i++) begin
         @(negedge clk);
         mem_we = 1'b1;
         mem_addr = AW'(i);
         mem_data = img[i];
      end
      @(negedge clk);
      mem_we = 1'b0;
      reset = 1'b0;

      // Normal load of the whole image
      $display("[TB] normal load");
      applyStimulus(1'b0, 0);
      snap = sck_rises;
      applyStimulus(1'b1, 0);
      cnt = 0;
      while (cnt < 20 && !sck) begin
         @(negedge clk);
         cnt++;
      end
      checkOutput("first_sck_latency", 32'(cnt), 32'd4);
      waitFor("wait_done_1", 0, 0, 200);
      checkOutput("t1_done", {31'd0, done}, 32'd1);
      checkOutput("t1_hold", {31'd0, cpu_hold_reset}, 32'd0);
      checkOutput("t1_busy", {31'd0, busy}, 32'd0);
      checkOutput("t1_load", {31'd0, load}, 32'd0);
      checkOutput("t1_last_data", 32'(data), 32'h0004);
      checkOutput("t1_index", 32'(word_index), 32'd3);
      checkOutput("t1_pulses", 32'(sck_rises - snap), 32'd4);

      // Abort after the second ack, then re-run from word 0
      $display("[TB] abort and re-run");
      applyStimulus(1'b0, 0);
      applyStimulus(1'b1, 0);
      waitFor("wait_ack_2", 4, ack_count + 2, 100);
      applyStimulus(1'b0, 0);
      @(negedge clk);
      checkOutput("abort_load", {31'd0, load}, 32'd0);
      checkOutput("abort_busy", {31'd0, busy}, 32'd0);
      checkOutput("abort_done", {31'd0, done}, 32'd0);
      checkOutput("abort_hold", {31'd0, cpu_hold_reset}, 32'd1);
      snap = sck_rises;
      applyStimulus(1'b1, 0);
      waitFor("rerun_sck", 2, 0, 20);
      checkOutput("rerun_index", 32'(word_index), 32'd0);
      checkOutput("rerun_data", 32'(data), 32'h0001);
      waitFor("wait_done_2", 0, 0, 200);
      checkOutput("rerun_pulses", 32'(sck_rises - snap), 32'd4);

      // Ack stuck high: only the first word completes until ack drops
      $display("[TB] stuck ack");
      applyStimulus(1'b0, 2);
      snap = sck_rises;
      applyStimulus(1'b1, 2);
      repeat (40) @(negedge clk);
      checkOutput("stuck_pulses", 32'(sck_rises - snap), 32'd1);
      checkOutput("stuck_busy", {31'd0, busy}, 32'd1);
      checkOutput("stuck_index", 32'(word_index), 32'd0);
      checkOutput("stuck_error", {31'd0, error}, 32'd0);
      applyStimulus(1'b1, 0);
      waitFor("wait_done_3", 0, 0, 200);
      checkOutput("stuck_total_pulses", 32'(sck_rises - snap), 32'd4);

      // Ack never arrives: error after 16 cycles in WAIT_ACK, then recover
      $display("[TB] ack timeout");
      applyStimulus(1'b0, 1);
      applyStimulus(1'b1, 1);
      waitFor("to_sck_hi", 2, 0, 20);
      waitFor("to_sck_lo", 3, 0, 10);
      cnt = 0;
      while (cnt < 40 && !error) begin
         @(negedge clk);
         cnt++;
      end
      checkOutput("timeout_cycles", 32'(cnt), 32'd16);
      checkOutput("to_error", {31'd0, error}, 32'd1);
      checkOutput("to_load", {31'd0, load}, 32'd0);
      checkOutput("to_hold", {31'd0, cpu_hold_reset}, 32'd1);
      checkOutput("to_busy", {31'd0, busy}, 32'd0);
      applyStimulus(1'b0, 0);
      applyStimulus(1'b1, 0);
      waitFor("wait_done_4", 0, 0, 200);
      checkOutput("recover_error", {31'd0, error}, 32'd0);

      // Async reset in the middle of the second word's sck-high phase
      $display("[TB] async reset");
      applyStimulus(1'b0, 0);
      applyStimulus(1'b1, 0);
      waitFor("ar_sck1", 2, 0, 20);
      waitFor("ar_sck1_lo", 3, 0, 10);
      waitFor("ar_sck2", 2, 0, 40);
      checkOutput("ar_pre_data", 32'(data), 32'h0002);
      #2 reset = 1'b1;
      #1;
      checkOutput("ar_sck", {31'd0, sck}, 32'd0);
      checkOutput("ar_load", {31'd0, load}, 32'd0);
      checkOutput("ar_busy", {31'd0, busy}, 32'd0);
      checkOutput("ar_data", 32'(data), 32'd0);
      checkOutput("ar_index", 32'(word_index), 32'd0);
      checkOutput("ar_hold", {31'd0, cpu_hold_reset}, 32'd1);
      run = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(1'b1, 0);
      waitFor("wait_done_5", 0, 0, 200);
      checkOutput("post_reset_data", 32'(data), 32'h0004);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
